// File: rtl/apxoa_col_comp.sv
//------------------------------------------------------------------------------
// Module      : apxoa_col_comp
// Description : Receive side of the approximate 8:2 column-compressor row.
//               Takes one compressed column per beat (LSB column first) and
//               rebuilds the approximate word. With APXOA_COMP_EN defined it
//               also rebuilds the error-compensated exact word and counts the
//               asserted error flags.
// Optional    : APXOA_COMP_EN (macro) - enables exact path and error counting.
// Ports       : clk, rst_n (sync, active low)
//               in_valid/in_ready/in_sum/in_carry/in_err[2:0]/in_last - column beat
//               out_valid/out_ready - result handshake
//               out_apx[RW-1:0], out_exact[RW-1:0] - rebuilt words
//               out_ncols - columns taken this frame, out_errcnt - error flags
//               out_ovf - frame was longer than MAX_COLS
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module apxoa_col_comp #(
  parameter int MAX_COLS = 16,
  parameter int ECW      = 6
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic                          in_sum,
  input  logic                          in_carry,
  input  logic [2:0]                    in_err,
  input  logic                          in_last,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [MAX_COLS+2:0]           out_apx,
  output logic [MAX_COLS+2:0]           out_exact,
  output logic [$clog2(MAX_COLS+1)-1:0] out_ncols,
  output logic [ECW-1:0]                out_errcnt,
  output logic                          out_ovf
);

  localparam int RW = MAX_COLS + 3;
  localparam int IW = $clog2(MAX_COLS);
  localparam int NW = $clog2(MAX_COLS + 1);

  localparam logic [NW-1:0] c_LAST_COL = NW'(MAX_COLS - 1);

  typedef enum logic [1:0] {
    ST_ACC   = 2'd0,
    ST_HOLD  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t        r_state;
  logic          r_valid;
  logic          r_ovf;
  logic [NW-1:0] r_ncols;
  logic [RW-1:0] r_apx;

  // While accumulating, the column count doubles as the column index; it
  // never reaches MAX_COLS inside ACC, so the low IW bits are sufficient.
  logic [IW-1:0] w_idx;
  logic [RW-1:0] w_apx_term;
  logic          w_close;

  assign w_idx      = r_ncols[IW-1:0];
  // {carry,sum} is the column value sum + 2*carry.
  assign w_apx_term = RW'({in_carry, in_sum}) << w_idx;
  assign w_close    = in_last || (r_ncols == c_LAST_COL);

`ifdef APXOA_COMP_EN
  logic [RW-1:0]  r_exact;
  logic [ECW-1:0] r_errcnt;
  logic [1:0]     w_pc;
  logic [RW-1:0]  w_exact_term;

  // Each flag marks one under-counted unit at this column's weight.
  assign w_pc         = {1'b0, in_err[0]} + {1'b0, in_err[1]} + {1'b0, in_err[2]};
  assign w_exact_term = (RW'({in_carry, in_sum}) + RW'(w_pc)) << w_idx;
`else
  logic w_unused_err;
  assign w_unused_err = ^in_err;
`endif

  // Gated by rst_n so the block never advertises readiness while held in reset.
  assign in_ready = rst_n && (r_state != ST_HOLD);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= ST_ACC;
      r_valid  <= 1'b0;
      r_ovf    <= 1'b0;
      r_ncols  <= '0;
      r_apx    <= '0;
`ifdef APXOA_COMP_EN
      r_exact  <= '0;
      r_errcnt <= '0;
`endif
    end else begin
      case (r_state)
        ST_ACC: begin
          if (in_valid) begin
            r_apx   <= r_apx + w_apx_term;
`ifdef APXOA_COMP_EN
            r_exact  <= r_exact + w_exact_term;
            r_errcnt <= r_errcnt + ECW'(w_pc);
`endif
            r_ncols <= r_ncols + NW'(1);
            if (w_close) begin
              r_state <= ST_HOLD;
              r_valid <= 1'b1;
              // Hitting the column limit without in_last means the frame
              // continues; its remainder is discarded in DRAIN.
              r_ovf   <= !in_last;
            end
          end
        end
        ST_HOLD: begin
          if (out_ready) begin
            r_valid  <= 1'b0;
            r_ovf    <= 1'b0;
            r_ncols  <= '0;
            r_apx    <= '0;
`ifdef APXOA_COMP_EN
            r_exact  <= '0;
            r_errcnt <= '0;
`endif
            r_state  <= r_ovf ? ST_DRAIN : ST_ACC;
          end
        end
        ST_DRAIN: begin
          if (in_valid && in_last) begin
            r_state <= ST_ACC;
          end
        end
        default: r_state <= ST_ACC;
      endcase
    end
  end

  assign out_valid = r_valid;
  assign out_apx   = r_apx;
  assign out_ncols = r_ncols;
  assign out_ovf   = r_ovf;

`ifdef APXOA_COMP_EN
  assign out_exact  = r_exact;
  assign out_errcnt = r_errcnt;
`else
  assign out_exact  = r_apx;
  assign out_errcnt = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_apxoa_col_comp.sv
//------------------------------------------------------------------------------
// Module      : tb_apxoa_col_comp
// Description : Directed-vector scoreboard bench for apxoa_col_comp.
//               Stimulus pushes hand-computed frame results into a queue; a
//               monitor pops and compares on every result handshake.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_apxoa_col_comp;

  localparam int MAX_COLS = 16;
  localparam int ECW      = 6;
  localparam int RW       = MAX_COLS + 3;
  localparam int NW       = $clog2(MAX_COLS + 1);

`ifdef APXOA_COMP_EN
  localparam bit c_COMP = 1'b1;
`else
  localparam bit c_COMP = 1'b0;
`endif

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic          in_sum;
  logic          in_carry;
  logic [2:0]    in_err;
  logic          in_last;
  logic          out_valid;
  logic          out_ready;
  logic [RW-1:0] out_apx;
  logic [RW-1:0] out_exact;
  logic [NW-1:0] out_ncols;
  logic [ECW-1:0] out_errcnt;
  logic          out_ovf;

  apxoa_col_comp #(.MAX_COLS(MAX_COLS), .ECW(ECW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sum     (in_sum),
    .in_carry   (in_carry),
    .in_err     (in_err),
    .in_last    (in_last),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_apx    (out_apx),
    .out_exact  (out_exact),
    .out_ncols  (out_ncols),
    .out_errcnt (out_errcnt),
    .out_ovf    (out_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int unsigned apx;
    int unsigned exact;
    int unsigned ncols;
    int unsigned errcnt;
    int unsigned ovf;
  } exp_t;

  exp_t q_exp[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Exact/errcnt collapse to apx/0 when compensation is not built.
  task automatic push_exp(input int unsigned apx, input int unsigned exact,
                          input int unsigned errcnt, input int unsigned ncols,
                          input int unsigned ovf);
    exp_t e;
    e.apx    = apx;
    e.exact  = c_COMP ? exact : apx;
    e.errcnt = c_COMP ? errcnt : 0;
    e.ncols  = ncols;
    e.ovf    = ovf;
    q_exp.push_back(e);
  endtask

  // Monitor: a result handshake happens on the next posedge whenever
  // out_valid && out_ready are both seen here.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (q_exp.size() == 0) begin
        chk("unexpected_result", 1, 0);
      end else begin
        exp_t e;
        e = q_exp.pop_front();
        chk("apx",    out_apx,    e.apx);
        chk("exact",  out_exact,  e.exact);
        chk("ncols",  out_ncols,  e.ncols);
        chk("errcnt", out_errcnt, e.errcnt);
        chk("ovf",    out_ovf,    e.ovf);
      end
    end
  end

  // Presents one beat and returns 1 time unit after the edge that took it.
  task automatic send_beat(input logic s, input logic c, input logic [2:0] e, input logic l);
    int waited;
    waited   = 0;
    in_valid = 1'b1;
    in_sum   = s;
    in_carry = c;
    in_err   = e;
    in_last  = l;
    do begin
      @(negedge clk);
      waited++;
    end while (!in_ready && waited < 200);
    if (!in_ready) begin
      chk("beat_accept_timeout", 0, 1);
    end else begin
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int waited;
    waited = 0;
    while (q_exp.size() != 0 && waited < 500) begin
      @(posedge clk);
      waited++;
    end
    if (q_exp.size() != 0) chk("result_timeout", q_exp.size(), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_sum    = 1'b0;
    in_carry  = 1'b0;
    in_err    = 3'b000;
    in_last   = 1'b0;
    out_ready = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready",  in_ready,  0);
    chk("rst_apx",       out_apx,   0);
    chk("rst_ncols",     out_ncols, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_in_ready", in_ready, 1);
    @(posedge clk);
    #1;

    // Test 1: single beat, all flags set
    push_exp(3, 6, 3, 1, 0);
    send_beat(1'b1, 1'b1, 3'b111, 1'b1);
    chk("t1_latency_valid", out_valid, 1);
    wait_idle();

    // Test 2: two beats
    push_exp(7, 9, 1, 2, 0);
    send_beat(1'b1, 1'b0, 3'b000, 1'b0);
    send_beat(1'b1, 1'b1, 3'b001, 1'b1);
    wait_idle();

    // Test 3: back-pressure with a beat held on the input
    out_ready = 1'b0;
    push_exp(3, 6, 3, 1, 0);
    send_beat(1'b1, 1'b1, 3'b111, 1'b1);
    in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("t3_hold_valid",    out_valid, 1);
      chk("t3_hold_in_ready", in_ready,  0);
      chk("t3_hold_apx",      out_apx,   3);
      chk("t3_hold_ncols",    out_ncols, 1);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("t3_post_in_ready",  in_ready,  1);
    chk("t3_post_out_valid", out_valid, 0);
    wait_idle();
    // A stray consumed beat would corrupt this frame.
    push_exp(7, 9, 1, 2, 0);
    send_beat(1'b1, 1'b0, 3'b000, 1'b0);
    send_beat(1'b1, 1'b1, 3'b001, 1'b1);
    wait_idle();

    // Test 4: 18-beat frame overflows, tail drained, then a normal frame
    push_exp(196605, 393210, 48, 16, 1);
    for (int k = 1; k <= 18; k++) begin
      send_beat(1'b1, 1'b1, 3'b111, (k == 18));
    end
    push_exp(3, 6, 3, 1, 0);
    send_beat(1'b1, 1'b1, 3'b111, 1'b1);
    wait_idle();

    // Test 5: reset mid-frame
    for (int k = 0; k < 3; k++) begin
      send_beat(1'b1, 1'b1, 3'b111, 1'b0);
    end
    rst_n = 1'b0;
    @(negedge clk);
    chk("t5_rst_out_valid", out_valid, 0);
    chk("t5_rst_in_ready",  in_ready,  0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("t5_post_ncols", out_ncols, 0);
    chk("t5_post_apx",   out_apx,   0);
    @(posedge clk);
    #1;
    push_exp(7, 9, 1, 2, 0);
    send_beat(1'b1, 1'b0, 3'b000, 1'b0);
    send_beat(1'b1, 1'b1, 3'b001, 1'b1);
    wait_idle();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
